// File: rtl/ps2_disp_pkg.sv
// Shared types and constants for the PS/2 scan-code display path.
package ps2_disp_pkg;

    // bit4 set = blank digit, bits 3:0 = hex value
    typedef logic [4:0] digit_t;

    localparam digit_t     DIGIT_BLANK = 5'b10000;
    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-digit to 7-segment decoder, active-low gfedcba; blank code lights nothing.
module seg7_hex_decoder
    import ps2_disp_pkg::*;
(
    input  digit_t     code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        if (!code[4]) begin
            case (code[3:0])
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                4'hF: seg = 7'h0E;
                default: seg = 7'h7F;
            endcase
        end
    end

endmodule

// File: rtl/ps2_code_history_display.sv
// Keeps a shifting hex history of accepted PS/2 scan-code bytes and scans it
// onto a multiplexed common-anode 7-segment display.
module ps2_code_history_display
    import ps2_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int FILTER_BREAK = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            CODE_IN,
    input  logic                  CODE_VALID,
    input  logic                  CLEAR,
    output logic [6:0]            SEG,
    output logic [NUM_DIGITS-1:0] DISP,
    output logic [7:0]            LAST_CODE,
    output logic [7:0]            CODE_CNT
);

    // A one-state counter still needs one bit to exist.
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    digit_t             digits [NUM_DIGITS];
    logic               break_pending;
    logic               break_next;
    logic               accept;
    logic [CNT_W-1:0]   refresh_cnt;
    logic [IDX_W-1:0]   idx;
    digit_t             cur_digit;
    logic [6:0]         cur_seg;

    always_comb begin
        accept     = 1'b0;
        break_next = break_pending;
        if (CODE_VALID) begin
            if (FILTER_BREAK == 0) begin
                accept = 1'b1;
            end else if (break_pending) begin
                break_next = 1'b0;
            end else if (CODE_IN == PS2_BREAK) begin
                break_next = 1'b1;
            end else if (CODE_IN != PS2_EXT) begin
                accept = 1'b1;
            end
        end
    end

    // Each accepted byte pushes two nibbles in at digit 0/1; the oldest byte drops off the top.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= DIGIT_BLANK;
            break_pending <= 1'b0;
            LAST_CODE     <= 8'h00;
            CODE_CNT      <= 8'h00;
        end else if (CLEAR) begin
            for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= DIGIT_BLANK;
            break_pending <= 1'b0;
        end else begin
            break_pending <= break_next;
            if (accept) begin
                for (int k = NUM_DIGITS - 1; k >= 2; k--) digits[k] <= digits[k-2];
                digits[1] <= {1'b0, CODE_IN[7:4]};
                digits[0] <= {1'b0, CODE_IN[3:0]};
                LAST_CODE <= CODE_IN;
                CODE_CNT  <= CODE_CNT + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign cur_digit = digits[idx];

    seg7_hex_decoder u_dec (
        .code (cur_digit),
        .seg  (cur_seg)
    );

    // Output stage: one cycle behind the scan index and history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DISP <= ~NUM_DIGITS'(1);
            SEG  <= 7'h7F;
        end else begin
            DISP <= ~(NUM_DIGITS'(1) << idx);
            SEG  <= cur_seg;
        end
    end

endmodule

// File: tb/tb_ps2_code_history_display.sv
// Bench for ps2_code_history_display: three configurations share one stimulus
// stream and are checked against a byte-level reference model.
module tb_ps2_code_history_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, code_valid, clear;
    logic [7:0] code_in;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [3:0] disp_a, disp_b;
    logic [5:0] disp_c;
    logic [7:0] last_a, last_b, last_c, cnt_a, cnt_b, cnt_c;

    ps2_code_history_display #(.NUM_DIGITS(4), .REFRESH_DIV(2), .FILTER_BREAK(1)) u_a (
        .CLK(clk), .RST(rst), .CODE_IN(code_in), .CODE_VALID(code_valid), .CLEAR(clear),
        .SEG(seg_a), .DISP(disp_a), .LAST_CODE(last_a), .CODE_CNT(cnt_a));
    ps2_code_history_display #(.NUM_DIGITS(4), .REFRESH_DIV(2), .FILTER_BREAK(0)) u_b (
        .CLK(clk), .RST(rst), .CODE_IN(code_in), .CODE_VALID(code_valid), .CLEAR(clear),
        .SEG(seg_b), .DISP(disp_b), .LAST_CODE(last_b), .CODE_CNT(cnt_b));
    ps2_code_history_display #(.NUM_DIGITS(6), .REFRESH_DIV(1), .FILTER_BREAK(1)) u_c (
        .CLK(clk), .RST(rst), .CODE_IN(code_in), .CODE_VALID(code_valid), .CLEAR(clear),
        .SEG(seg_c), .DISP(disp_c), .LAST_CODE(last_c), .CODE_CNT(cnt_c));

    logic [6:0] seg_o  [3];
    logic [5:0] disp_o [3];
    logic [7:0] last_o [3];
    logic [7:0] cnt_o  [3];
    assign seg_o[0] = seg_a;  assign disp_o[0] = {2'b00, disp_a};
    assign seg_o[1] = seg_b;  assign disp_o[1] = {2'b00, disp_b};
    assign seg_o[2] = seg_c;  assign disp_o[2] = disp_c;
    assign last_o[0] = last_a; assign cnt_o[0] = cnt_a;
    assign last_o[1] = last_b; assign cnt_o[1] = cnt_b;
    assign last_o[2] = last_c; assign cnt_o[2] = cnt_c;

    int errors = 0;
    int checks = 0;

    localparam int ND [3] = '{4, 4, 6};
    localparam int RD [3] = '{2, 2, 1};
    localparam int FB [3] = '{1, 0, 1};
    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: history kept as accepted bytes (newest at slot 0), scan position from cycle count.
    logic [7:0] mbyte [3][3];
    bit         mval  [3][3];
    bit         mpend [3];
    int         mt    [3];
    logic [7:0] mlast [3];
    logic [7:0] mcnt  [3];
    logic [6:0] eseg  [3];
    logic [5:0] edisp [3];

    function automatic logic [6:0] model_seg(int c, int k);
        int j;
        logic [7:0] b;
        j = k / 2;
        if (!mval[c][j]) return 7'h7F;
        b = mbyte[c][j];
        return (k % 2 == 1) ? DEC[b[7:4]] : DEC[b[3:0]];
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            int idx;
            bit acc;
            if (rst) begin
                for (int j = 0; j < 3; j++) mval[c][j] = 1'b0;
                mpend[c] = 1'b0;
                mt[c]    = 0;
                mlast[c] = 8'h00;
                mcnt[c]  = 8'h00;
                edisp[c] = 6'(((1 << ND[c]) - 1) & ~1);
                eseg[c]  = 7'h7F;
            end else begin
                idx      = (mt[c] / RD[c]) % ND[c];
                edisp[c] = 6'(((1 << ND[c]) - 1) & ~(1 << idx));
                eseg[c]  = model_seg(c, idx);
                mt[c]++;
                if (clear) begin
                    for (int j = 0; j < 3; j++) mval[c][j] = 1'b0;
                    mpend[c] = 1'b0;
                end else if (code_valid) begin
                    acc = 1'b1;
                    if (FB[c] != 0) begin
                        if (mpend[c]) begin
                            mpend[c] = 1'b0; acc = 1'b0;
                        end else if (code_in == 8'hF0) begin
                            mpend[c] = 1'b1; acc = 1'b0;
                        end else if (code_in == 8'hE0) begin
                            acc = 1'b0;
                        end
                    end
                    if (acc) begin
                        for (int j = ND[c] / 2 - 1; j >= 1; j--) begin
                            mbyte[c][j] = mbyte[c][j-1];
                            mval[c][j]  = mval[c][j-1];
                        end
                        mbyte[c][0] = code_in;
                        mval[c][0]  = 1'b1;
                        mlast[c]    = code_in;
                        mcnt[c]     = mcnt[c] + 8'd1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; code_valid = 1'b0; clear = 1'b0; code_in = 8'h00;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (disp_a !== 4'b1110 || seg_a !== 7'h7F) begin
            errors++;
            $display("FAIL reset_out: disp=%b seg=%h, expected disp=1110 seg=7f", disp_a, seg_a);
        end
        checks++;
        if (cnt_a !== 8'h00 || last_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: cnt=%h last=%h, expected 00 00", cnt_a, last_a);
        end
        for (int n = 0; n < 12; n++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (disp_o[c] !== edisp[c] || seg_o[c] !== eseg[c]) begin
                    errors++;
                    $display("FAIL reset_scan dut%0d: disp=%b seg=%h, expected disp=%b seg=%h",
                             c, disp_o[c], seg_o[c], edisp[c], eseg[c]);
                end
            end
        end
    endtask

    task automatic test_accept();
        code_valid = 1'b1; code_in = 8'h1C; tick();
        code_in = 8'h2B; tick();
        code_valid = 1'b0;
        checks++;
        if (cnt_a !== 8'd2 || last_a !== 8'h2B) begin
            errors++;
            $display("FAIL accept_regs: cnt=%h last=%h, expected 02 2b", cnt_a, last_a);
        end
        for (int n = 0; n < 10; n++) begin
            logic [6:0] want;
            tick();
            case (disp_a)
                4'b0111: want = 7'h79;
                4'b1011: want = 7'h46;
                4'b1101: want = 7'h24;
                default: want = 7'h03;
            endcase
            checks++;
            if (seg_a !== want || disp_a !== edisp[0]) begin
                errors++;
                $display("FAIL accept_scan: disp=%b seg=%h, expected disp=%b seg=%h",
                         disp_a, seg_a, edisp[0], want);
            end
            for (int c = 1; c < 3; c++) begin
                checks++;
                if (disp_o[c] !== edisp[c] || seg_o[c] !== eseg[c]) begin
                    errors++;
                    $display("FAIL accept_model dut%0d: disp=%b seg=%h, expected disp=%b seg=%h",
                             c, disp_o[c], seg_o[c], edisp[c], eseg[c]);
                end
            end
        end
    endtask

    task automatic test_break_filter();
        logic [7:0] seq [4] = '{8'hF0, 8'h1C, 8'hE0, 8'h75};
        for (int i = 0; i < 4; i++) begin
            code_valid = 1'b1; code_in = seq[i]; tick();
        end
        code_valid = 1'b0;
        checks++;
        if (cnt_a !== 8'd3 || last_a !== 8'h75) begin
            errors++;
            $display("FAIL filter_regs: cnt=%h last=%h, expected 03 75", cnt_a, last_a);
        end
        checks++;
        if (cnt_b !== 8'd6 || last_b !== 8'h75) begin
            errors++;
            $display("FAIL nofilter_regs: cnt=%h last=%h, expected 06 75", cnt_b, last_b);
        end
        for (int n = 0; n < 10; n++) begin
            logic [6:0] want;
            tick();
            case (disp_a)
                4'b0111: want = 7'h24;
                4'b1011: want = 7'h03;
                4'b1101: want = 7'h78;
                default: want = 7'h12;
            endcase
            checks++;
            if (seg_a !== want) begin
                errors++;
                $display("FAIL filter_scan: disp=%b seg=%h, expected seg=%h", disp_a, seg_a, want);
            end
            checks++;
            if (disp_b !== edisp[1] || seg_b !== eseg[1]) begin
                errors++;
                $display("FAIL nofilter_scan: disp=%b seg=%h, expected disp=%b seg=%h",
                         disp_b, seg_b, edisp[1], eseg[1]);
            end
        end
        // a fresh byte must be accepted, proving no break is still pending
        code_valid = 1'b1; code_in = 8'h5A; tick();
        code_valid = 1'b0;
        checks++;
        if (cnt_a !== 8'd4 || last_a !== 8'h5A) begin
            errors++;
            $display("FAIL pending_cleared: cnt=%h last=%h, expected 04 5a", cnt_a, last_a);
        end
    endtask

    task automatic test_clear_and_reset();
        clear = 1'b1; code_valid = 1'b1; code_in = 8'h33; tick();
        clear = 1'b0; code_valid = 1'b0;
        checks++;
        if (cnt_a !== 8'd4 || last_a !== 8'h5A || cnt_b !== mcnt[1] || last_b !== mlast[1]) begin
            errors++;
            $display("FAIL clear_regs: cnt=%h last=%h, expected 04 5a", cnt_a, last_a);
        end
        for (int n = 0; n < 9; n++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (seg_o[c] !== 7'h7F || disp_o[c] !== edisp[c]) begin
                    errors++;
                    $display("FAIL clear_blank dut%0d: disp=%b seg=%h, expected disp=%b seg=7f",
                             c, disp_o[c], seg_o[c], edisp[c]);
                end
            end
        end
        rst = 1'b1; tick();
        rst = 1'b0;
        checks++;
        if (disp_a !== 4'b1110 || disp_c !== 6'b111110) begin
            errors++;
            $display("FAIL midscan_reset: disp_a=%b disp_c=%b, expected 1110 111110", disp_a, disp_c);
        end
        tick();
        checks++;
        if (disp_a !== 4'b1110 || disp_c !== 6'b111110 || cnt_a !== 8'h00) begin
            errors++;
            $display("FAIL post_reset: disp_a=%b disp_c=%b cnt=%h, expected 1110 111110 00",
                     disp_a, disp_c, cnt_a);
        end
    endtask

    task automatic test_six_digits();
        logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [5:0] prev;
        for (int i = 0; i < 4; i++) begin
            code_valid = 1'b1; code_in = seq[i]; tick();
        end
        code_valid = 1'b0;
        checks++;
        if (cnt_c !== 8'd4 || last_c !== 8'h44) begin
            errors++;
            $display("FAIL six_regs: cnt=%h last=%h, expected 04 44", cnt_c, last_c);
        end
        tick();
        prev = disp_c;
        for (int n = 0; n < 8; n++) begin
            logic [6:0] want;
            tick();
            case (disp_c)
                6'b111110, 6'b111101: want = 7'h19;
                6'b111011, 6'b110111: want = 7'h30;
                default:              want = 7'h24;
            endcase
            checks++;
            if (seg_c !== want || disp_c === prev || disp_c !== edisp[2]) begin
                errors++;
                $display("FAIL six_scan: disp=%b seg=%h prev=%b, expected disp=%b seg=%h",
                         disp_c, seg_c, prev, edisp[2], want);
            end
            prev = disp_c;
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            code_valid = 1'b1;
            code_in    = 8'($urandom_range(0, 255));
            tick();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (cnt_o[c] !== mcnt[c] || last_o[c] !== mlast[c] ||
                    seg_o[c] !== eseg[c] || disp_o[c] !== edisp[c]) begin
                    errors++;
                    $display("FAIL b2b dut%0d: cnt=%h last=%h seg=%h disp=%b, expected %h %h %h %b",
                             c, cnt_o[c], last_o[c], seg_o[c], disp_o[c],
                             mcnt[c], mlast[c], eseg[c], edisp[c]);
                end
            end
        end
        code_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            clear      = ($urandom_range(0, 24) == 0);
            code_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0:       code_in = 8'hF0;
                1:       code_in = 8'hE0;
                default: code_in = 8'($urandom_range(0, 255));
            endcase
            tick();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (cnt_o[c] !== mcnt[c] || last_o[c] !== mlast[c] ||
                    seg_o[c] !== eseg[c] || disp_o[c] !== edisp[c]) begin
                    errors++;
                    $display("FAIL random dut%0d: cnt=%h last=%h seg=%h disp=%b, expected %h %h %h %b",
                             c, cnt_o[c], last_o[c], seg_o[c], disp_o[c],
                             mcnt[c], mlast[c], eseg[c], edisp[c]);
                end
            end
        end
        rst = 1'b0; clear = 1'b0; code_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; code_valid = 1'b0; clear = 1'b0; code_in = 8'h00;
        test_reset();
        test_accept();
        test_break_filter();
        test_clear_and_reset();
        test_six_digits();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
